// File: rtl/regpair_sequencer.sv
// Register-pair sequencer: turns one start request into the read/modify/write
// sequence needed for 16-bit pair READ, LOAD, INX and DCX on an 8-bit registerfile.
module regpair_sequencer #(
   parameter int DATASIZE = 8,
   parameter int REGBIT   = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [1:0]              cmd,
   input  logic [REGBIT-2:0]       psel,
   input  logic [2*DATASIZE-1:0]   pdin,
   output logic                    busy,
   output logic                    done,
   output logic [2*DATASIZE-1:0]   pdata,
   output logic                    wrenb,
   output logic [REGBIT-1:0]       waddr,
   output logic [DATASIZE-1:0]     wdata,
   output logic                    r1enb,
   output logic                    r2enb,
   output logic [REGBIT-1:0]       r1add,
   output logic [REGBIT-1:0]       r2add,
   input  logic [DATASIZE-1:0]     r1dat,
   input  logic [DATASIZE-1:0]     r2dat
);

   localparam int PW = 2 * DATASIZE;

   typedef enum logic [2:0] {IDLE, RDEN, RDCAP, WRLO, WRHI, DONE} state_e;
   typedef enum logic [1:0] {C_READ = 2'b00, C_LOAD = 2'b01, C_INX = 2'b10, C_DCX = 2'b11} cmd_e;

   state_e            state;
   cmd_e              lcmd;
   logic [REGBIT-2:0] lpsel;
   logic [PW-1:0]     result;
   logic [PW-1:0]     operand;
   logic [PW-1:0]     step;

   assign operand = {r1dat, r2dat};
   assign step    = (lcmd == C_DCX) ? operand - PW'(1) : operand + PW'(1);

   // Outputs are set on the edge entering each state so they line up with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         lcmd   <= C_READ;
         lpsel  <= '0;
         result <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         pdata  <= '0;
         wrenb  <= 1'b0;
         waddr  <= '0;
         wdata  <= '0;
         r1enb  <= 1'b0;
         r2enb  <= 1'b0;
         r1add  <= '0;
         r2add  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  lcmd  <= cmd_e'(cmd);
                  lpsel <= psel;
                  busy  <= 1'b1;
                  if (cmd_e'(cmd) == C_LOAD) begin
                     result <= pdin;
                     wrenb  <= 1'b1;
                     waddr  <= {psel, 1'b1};
                     wdata  <= pdin[DATASIZE-1:0];
                     state  <= WRLO;
                  end else begin
                     r1enb <= 1'b1;
                     r2enb <= 1'b1;
                     r1add <= {psel, 1'b0};
                     r2add <= {psel, 1'b1};
                     state <= RDEN;
                  end
               end
            end
            RDEN: state <= RDCAP;
            RDCAP: begin
               r1enb <= 1'b0;
               r2enb <= 1'b0;
               if (lcmd == C_READ) begin
                  pdata <= operand;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  result <= step;
                  wrenb  <= 1'b1;
                  waddr  <= {lpsel, 1'b1};
                  wdata  <= step[DATASIZE-1:0];
                  state  <= WRLO;
               end
            end
            WRLO: begin
               waddr <= {lpsel, 1'b0};
               wdata <= result[PW-1:DATASIZE];
               state <= WRHI;
            end
            WRHI: begin
               wrenb <= 1'b0;
               pdata <= result;
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_regpair_sequencer.sv
// Bench for regpair_sequencer: behavioural registerfile plus a pair-level model.
module tb_regpair_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  cmd = '0;
   logic [1:0]  psel = '0;
   logic [15:0] pdin = '0;
   logic        busy, done, wrenb, r1enb, r2enb;
   logic [15:0] pdata;
   logic [2:0]  waddr, r1add, r2add;
   logic [7:0]  wdata;
   logic [7:0]  r1dat = '0;
   logic [7:0]  r2dat = '0;

   logic [7:0]  regs [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
   logic [15:0] expp [4];
   logic [10:0] wlog [$];
   logic [6:0]  rlog [$];
   int          dtimes [$];
   int          errors = 0;
   int          checks = 0;
   int          dcount = 0;
   int          cyc = 0;

   regpair_sequencer #(.DATASIZE(8), .REGBIT(3)) dut (
      .clk(clk), .rst(rst), .start(start), .cmd(cmd), .psel(psel), .pdin(pdin),
      .busy(busy), .done(done), .pdata(pdata), .wrenb(wrenb), .waddr(waddr),
      .wdata(wdata), .r1enb(r1enb), .r2enb(r2enb), .r1add(r1add), .r2add(r2add),
      .r1dat(r1dat), .r2dat(r2dat)
   );

   always #5 clk = ~clk;

   // Registerfile: synchronous write, read data valid the cycle after enable.
   always @(posedge clk) begin
      if (wrenb) begin
         regs[waddr] <= wdata;
         wlog.push_back({waddr, wdata});
      end
      if (r1enb) r1dat <= regs[r1add];
      if (r2enb) r2dat <= regs[r2add];
   end

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (done) begin
         dcount <= dcount + 1;
         dtimes.push_back(cyc);
      end
      if (r1enb) rlog.push_back({r1add, r2add, r2enb});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, want);
      end
   endtask

   function automatic logic [15:0] pairval(input int p);
      return {regs[2*p], regs[2*p+1]};
   endfunction

   task automatic do_cmd(input logic [1:0] c, input logic [1:0] p, input logic [15:0] d, input bit hold);
      logic [15:0] want;
      int lat;
      logic [2:0] hi, lo;
      hi = {p, 1'b0};
      lo = {p, 1'b1};
      @(negedge clk);
      start = 1'b1; cmd = c; psel = p; pdin = d;
      wlog.delete(); rlog.delete();
      @(posedge clk); #1;
      cmd = 2'($urandom); psel = 2'($urandom); pdin = 16'($urandom);
      if (!hold) start = 1'b0;
      lat = 0;
      for (int i = 1; i <= 12 && lat == 0; i++) begin
         @(negedge clk);
         if (done) lat = i;
      end
      start = 1'b0;
      case (c)
         2'b00:   want = expp[p];
         2'b01:   want = d;
         2'b10:   want = expp[p] + 16'd1;
         default: want = expp[p] - 16'd1;
      endcase
      expp[p] = want;
      chk("latency", lat, (c == 2'b10 || c == 2'b11) ? 5 : 3);
      chk("pdata", {16'h0, pdata}, {16'h0, want});
      chk("nreads", rlog.size(), (c == 2'b01) ? 0 : 2);
      if (c != 2'b01 && rlog.size() == 2) begin
         chk("rd_addr0", {25'h0, rlog[0]}, {25'h0, hi, lo, 1'b1});
         chk("rd_addr1", {25'h0, rlog[1]}, {25'h0, hi, lo, 1'b1});
      end
      chk("nwrites", wlog.size(), (c == 2'b00) ? 0 : 2);
      if (c != 2'b00 && wlog.size() == 2) begin
         chk("wr_lo", {21'h0, wlog[0]}, {21'h0, lo, want[7:0]});
         chk("wr_hi", {21'h0, wlog[1]}, {21'h0, hi, want[15:8]});
      end
      @(negedge clk);
      chk("busy_after", {31'h0, busy}, 32'h0);
      chk("pair", {16'h0, pairval(p)}, {16'h0, want});
      chk("pdata_hold", {16'h0, pdata}, {16'h0, want});
   endtask

   initial begin
      int d0, wr0;
      for (int i = 0; i < 4; i++) expp[i] = {regs[2*i], regs[2*i+1]};
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("reset_ctl", {27'h0, busy, done, wrenb, r1enb, r2enb}, 32'h0);
      chk("reset_data", {pdata, waddr, r1add, r2add, wdata[6:0]}, 32'h0);
      chk("reset_wd7", {31'h0, wdata[7]}, 32'h0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle_en", {28'h0, busy, wrenb, r1enb, r2enb}, 32'h0);
      end

      do_cmd(2'b01, 2'b10, 16'hA55A, 1'b0);
      do_cmd(2'b00, 2'b10, 16'h0000, 1'b0);
      do_cmd(2'b01, 2'b00, 16'hFFFF, 1'b0);
      do_cmd(2'b10, 2'b00, 16'h0000, 1'b0);
      do_cmd(2'b11, 2'b00, 16'h0000, 1'b0);
      do_cmd(2'b10, 2'b01, 16'h0000, 1'b1);
      do_cmd(2'b01, 2'b01, 16'h12FF, 1'b0);

      // INX DE with reset asserted during WRHI.
      d0 = dcount;
      @(negedge clk);
      start = 1'b1; cmd = 2'b10; psel = 2'b01;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rstmid_ctl", {29'h0, busy, done, wrenb}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rstmid_lo", {24'h0, regs[3]}, 32'h00);
      chk("rstmid_hi", {24'h0, regs[2]}, 32'h12);
      chk("rstmid_done", dcount - d0, 0);
      expp[1] = 16'h1200;

      // Back-to-back LOAD DE with start held high.
      dtimes.delete(); wlog.delete();
      d0 = dcount;
      @(negedge clk);
      start = 1'b1; cmd = 2'b01; psel = 2'b01; pdin = 16'h1234;
      repeat (12) @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      chk("b2b_dones", dcount - d0, 3);
      chk("b2b_writes", wlog.size(), 6);
      if (dtimes.size() == 3) begin
         chk("b2b_gap1", dtimes[1] - dtimes[0], 4);
         chk("b2b_gap2", dtimes[2] - dtimes[1], 4);
      end
      chk("b2b_pair", {16'h0, pairval(1)}, 32'h1234);
      expp[1] = 16'h1234;

      for (int n = 0; n < 40; n++) begin
         wr0 = $urandom_range(0, 3);
         do_cmd(2'(wr0), 2'($urandom), 16'($urandom), 1'($urandom));
      end
      for (int i = 0; i < 4; i++) chk("final_pair", {16'h0, pairval(i)}, {16'h0, expp[i]});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regpair_sequencer.md
Name: regpair_sequencer

Overview:
- Controller that sequences the 8-bit registerfile to perform 16-bit register-pair operations: READ, LOAD, INX and DCX (8085 pair semantics).
- Sits between the instruction decoder and the registerfile.
- Owns the registerfile write port and both read ports while busy.
- Converts one start request into the multi-cycle read/modify/write sequence on the single write port.

Parameters:
- DATASIZE, 8, registerfile data width; pair width is 2*DATASIZE.
- REGBIT, 3, registerfile address width; pair select width is REGBIT-1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-low
- start  input  1  command request; sampled only in IDLE
- cmd  input  2  00 READ, 01 LOAD, 10 INX, 11 DCX
- psel  input  REGBIT-1  pair select: 00 BC, 01 DE, 10 HL, 11 regs 6/7
- pdin  input  2*DATASIZE  LOAD value
- busy  output  1  high while a command is in progress
- done  output  1  one-cycle completion pulse
- pdata  output  2*DATASIZE  READ result, or new pair value after LOAD/INX/DCX
- wrenb  output  1  registerfile write enable
- waddr  output  REGBIT  registerfile write address
- wdata  output  DATASIZE  registerfile write data
- r1enb, r2enb  output  1  registerfile read enables
- r1add, r2add  output  REGBIT  registerfile read addresses
- r1dat, r2dat  input  DATASIZE  registerfile read data

Behaviour:
- Pair mapping:
  - high register = {psel,1'b0}, low register = {psel,1'b1}.
  - r1 port always reads high, r2 port always reads low.
- States: IDLE, RDEN, RDCAP, WRLO, WRHI, DONE.
- IDLE, start=1 at an edge:
  - latch cmd, psel, pdin.
  - READ/INX/DCX go to RDEN; LOAD goes to WRLO.
- Ignored starts: start while busy=1 has no effect; start=0 in IDLE keeps IDLE.
- RDEN:
  - r1enb=r2enb=1, r1add=high, r2add=low; go to RDCAP.
  - Registerfile read data is valid during the cycle after enable.
- RDCAP:
  - enables held at 1, addresses held.
  - At the edge, capture {r1dat,r2dat} as the operand.
  - READ goes to DONE with pdata = operand.
  - INX/DCX go to WRLO with result = operand+1 / operand-1, modulo 2^(2*DATASIZE).
- Wrap-around: FFFF+1 -> 0000 and 0000-1 -> FFFF. No flag output; INX/DCX affect no flags.
- WRLO: wrenb=1, waddr=low, wdata=result[DATASIZE-1:0]; go to WRHI. LOAD result = latched pdin.
- WRHI: wrenb=1, waddr=high, wdata=result[2*DATASIZE-1:DATASIZE]; pdata = result; go to DONE.
- DONE: done=1 for exactly one cycle, busy=1; go to IDLE. A start in DONE is ignored.
- Outputs:
  - busy = (state != IDLE).
  - All enables are decoded from registered state only (glitch-free); all enables are 0 in IDLE and DONE.
- Latency from the start-sampling edge to done high:
  - LOAD: 3 cycles
  - READ: 3 cycles
  - INX/DCX: 5 cycles
- Each command is followed by at least one IDLE cycle.
- pdata holds its last value until the next command updates it.
- Reset (rst=0, any time):
  - state=IDLE; busy, done, wrenb, r1enb, r2enb = 0; waddr, r1add, r2add, wdata, pdata = 0.
  - No further registerfile writes occur.
  - Reset between WRLO and WRHI leaves the pair half-updated (low byte new); this is accepted behaviour.
- Changes to cmd, psel or pdin after acceptance do not affect the command in flight.

Test Plan:
- Reset: hold rst=0 for 5 clocks -> all outputs 0, state IDLE; after release, idle 3 clocks with start=0 -> no enable asserted.
- LOAD: cmd=01, psel=10 (HL), pdin=A55A -> wrenb pulses waddr=5 data=5A, then waddr=4 data=A5; done 3 cycles after start; registerfile regs 4/5 = A5/5A.
- READ: after the load, cmd=00, psel=10 -> r1add=4, r2add=5 enabled for 2 cycles; done at 3 cycles; pdata=A55A.
- INX wrap: LOAD BC=FFFF, then INX BC -> writes reg1=00 then reg0=00; done at 5 cycles; pdata=0000. DCX BC then gives FFFF.
- Busy and reset: start INX DE while busy with a prior command -> ignored, no extra writes. Start INX DE (DE=12FF), assert rst=0 during WRHI -> reg3=00, reg2=12 unchanged, busy=0, done never pulses.
- Back-to-back: start held high continuously with LOAD DE=1234 -> one command per 4-cycle period; done pulses separated by the IDLE cycle; final DE=1234.
